// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared states, piece codes and constants for the tetris game controller
package tetris_pkg;

  localparam int ROWS_DEF = 4;
  localparam int COLS_DEF = 8;

  localparam logic [3:0] LFSR_SEED = 4'b1001;

  typedef logic [1:0] piece_t;
  localparam piece_t PIECE_I = 2'b00;
  localparam piece_t PIECE_O = 2'b01;
  localparam piece_t PIECE_T = 2'b10;
  localparam piece_t PIECE_L = 2'b11;

  typedef enum logic [2:0] {IDLE, SPAWN, FALL, CHECK, CLEAR, OVER} state_t;

endpackage

// File: rtl/tetris_game_ctrl_gravity_timer.sv
// rtl/tetris_game_ctrl_gravity_timer.sv - gravity divider: counts while enabled, ticks at period-1
module gravity_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = enable && (cnt == period - W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/tetris_game_ctrl.sv
// rtl/tetris_game_ctrl.sv - game sequencer: spawn, gravity, line-clear handshake; TETRIS_SPEEDUP_EN shortens gravity
module tetris_game_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS        = ROWS_DEF,
  parameter int COLS        = COLS_DEF,
  parameter int TICK_DIV    = 16,
  parameter int CLR_TIMEOUT = 8
) (
  input  logic                 clka,
  input  logic                 restart,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] board_in,
  input  logic                 landed,
  input  logic                 clr_done,
  input  logic                 clr_error,
  output logic                 spawn,
  output logic [1:0]           curr_piece,
  output logic                 drop_tick,
  output logic                 clr_req,
  output logic [7:0]           lines_cleared,
  output logic                 busy,
  output logic                 game_over,
  output logic                 error
);

  localparam int TW = $clog2(TICK_DIV) + 1;
  localparam int WW = $clog2(CLR_TIMEOUT) + 1;
  localparam int NW = $clog2(ROWS + 1);

  state_t        state, state_next;
  logic [3:0]    lfsr;
  logic [WW-1:0] wd_cnt;
  logic [TW-1:0] period;
  logic          tick;
  logic          top_occupied;
  logic [NW-1:0] full_rows;
  logic          clr_fault;
  logic [8:0]    lines_sum;

  assign top_occupied = |board_in[(ROWS-1)*COLS +: COLS];

  always_comb begin
    full_rows = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (&board_in[r*COLS +: COLS]) full_rows = full_rows + NW'(1);
    end
  end

  assign lines_sum = {1'b0, lines_cleared} + 9'(full_rows);

  // clr_done on the last allowed cycle still counts; clr_error always wins
  assign clr_fault = clr_error || (wd_cnt == WW'(CLR_TIMEOUT - 1) && !clr_done);

`ifdef TETRIS_SPEEDUP_EN
  logic [TW-1:0] period_shifted;
  assign period_shifted = TW'(TICK_DIV) >> lines_cleared[7:2];

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      period <= TW'(TICK_DIV);
    end else if (state == SPAWN) begin
      period <= (period_shifted < TW'(2)) ? TW'(2) : period_shifted;
    end
  end
`else
  assign period = TW'(TICK_DIV);
`endif

  gravity_timer #(.W(TW)) u_gravity_timer (
    .clk    (clka),
    .rst    (restart),
    .clear  (state == SPAWN),
    .enable (state == FALL),
    .period (period),
    .tick   (tick)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SPAWN;
      SPAWN:   state_next = top_occupied ? OVER : FALL;
      FALL:    if (landed) state_next = CHECK;
      CHECK:   state_next = (full_rows != '0) ? CLEAR : SPAWN;
      CLEAR: begin
        if (clr_fault)     state_next = OVER;
        else if (clr_done) state_next = CHECK;
      end
      OVER:    if (start) state_next = SPAWN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      curr_piece    <= PIECE_I;
      drop_tick     <= 1'b0;
      lines_cleared <= '0;
      error         <= 1'b0;
      wd_cnt        <= '0;
    end else begin
      state     <= state_next;
      // landing beats a coincident gravity tick
      drop_tick <= tick && !landed;
      case (state)
        SPAWN: begin
          if (!top_occupied) begin
            curr_piece <= lfsr[1:0];
            lfsr       <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
          end
        end
        CHECK: begin
          wd_cnt        <= '0;
          lines_cleared <= lines_sum[8] ? 8'hFF : lines_sum[7:0];
        end
        CLEAR: begin
          wd_cnt <= wd_cnt + WW'(1);
          if (clr_fault) error <= 1'b1;
        end
        OVER: begin
          if (start) begin
            lines_cleared <= '0;
            error         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign spawn     = (state == SPAWN);
  assign clr_req   = (state == CLEAR);
  assign busy      = (state != IDLE) && (state != OVER);
  assign game_over = (state == OVER);

endmodule
